id_stage_pipe: RTL and testbench
================================

Name: id_stage_pipe

Overview:
- Parametrised, registered instruction-decode stage for the 5-stage MIPS-subset pipeline.
- Decodes R-type, lw, sw and beqz, and adds the behaviour the combinational decoder lacks:
  - ID/EX pipeline register with valid/ready handshake
  - load-use hazard stall
  - write-back bypass
  - branch target generation
  - flush
- Sits between the IF/ID register and EX.

Parameters:
- DATA_W, 32, datapath and register width.
- REG_AW, 5, register-file address width (instruction fields are fixed 5-bit; zero-extended/truncated to REG_AW).
- PC_W, 32, program counter width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  IF/ID holds a valid instruction.
- in_ready  out  1  stage accepts the instruction this cycle.
- in_instr  in  32  instruction word.
- in_pc  in  PC_W  address of in_instr.
- rs_addr  out  REG_AW  register-file read address A, combinational from in_instr[25:21].
- rt_addr  out  REG_AW  read address B, combinational from in_instr[20:16].
- rs_data  in  DATA_W  register-file read data A, same cycle.
- rt_data  in  DATA_W  register-file read data B, same cycle.
- wb_en  in  1  write-back port write enable.
- wb_addr  in  REG_AW  write-back destination.
- wb_data  in  DATA_W  write-back value.
- flush  in  1  squash held and incoming instruction.
- out_valid  out  1  ID/EX register valid.
- out_ready  in  1  EX accepts the ID/EX contents.
- out_opcode  out  6  registered opcode.
- out_rd  out  REG_AW  destination register (rd for R-type, rt for lw/sw).
- out_imm  out  DATA_W  sign-extended imm16.
- out_rs_val  out  DATA_W  operand A.
- out_rt_val  out  DATA_W  operand B; store data for sw.
- out_mem_read  out  1  lw.
- out_mem_write  out  1  sw.
- out_reg_write  out  1  R-type or lw, and destination != 0.
- out_br_taken  out  1  beqz taken (operand A == 0).
- out_br_target  out  PC_W  in_pc + 4 + (imm << 2), modulo 2^PC_W.
- out_illegal  out  1  unknown opcode; all other control bits 0.

Behaviour:
- Reset: out_valid and all control outputs 0; data outputs 0; stall state cleared. Reset mid-transfer discards the held instruction.
- Handshake: fire_in = in_valid && in_ready; fire_out = out_valid && out_ready.
- in_ready = !hazard && (!out_valid || out_ready).
- Latency: one cycle. Decode of a fired instruction appears on out_* the next edge.
- Hold: while out_valid && !out_ready, all out_* are stable.
- Load-use hazard:
  - Condition: out_valid && out_mem_read && out_rd != 0, and out_rd matches a source actually used by in_instr. R-type uses rs and rt; lw uses rs; sw uses rs and rt; beqz uses rs.
  - Effect: in_ready = 0. When EX accepts the lw, a bubble is loaded (out_valid = 0). The dependent instruction is accepted the following cycle, so exactly 1 bubble is inserted.
- Write-back bypass: if wb_en && wb_addr != 0 && wb_addr == source address, the operand uses wb_data instead of the register-file data. This applies to both operands and to the beqz compare.
- Register 0 always reads as 0, regardless of rs_data/rt_data.
- Opcode handling:
  - 000000 R-type: operands rs and rt.
  - 100011 lw: operand A = rs, imm.
  - 101011 sw: operand A = rs, operand B = rt as store data, imm.
  - 000100 beqz: operand A = rs, operand B = 0.
  - Any other opcode: out_illegal = 1 with out_valid = 1.
- Flush priority:
  - flush overrides everything: the next edge clears out_valid.
  - in_ready is forced to 1 during flush, so a simultaneous in_valid instruction is consumed and dropped.
  - Flush during a hazard stall also clears the stall.
- Simultaneous events: a fire_out and fire_in in the same cycle load the new instruction (back-to-back throughput of 1 per cycle). out_ready while out_valid = 0 has no effect.

Decomposition:
- Package id_pkg holds:
  - opcode localparams: OP_RTYPE, OP_LW, OP_SW, OP_BEQZ
  - instruction field slice constants
  - struct id_ex_t grouping all out_* fields
- One natural sub-module, id_decode: a purely combinational opcode-to-control decode with operand select and bypass. It is instantiated inside id_stage_pipe, which owns the register, handshake and hazard logic.

Test Plan:
- Reset asserted mid-stream with out_valid = 1 -> out_valid = 0 asynchronously and all control outputs 0; first instruction after release appears 1 cycle after acceptance.
- lw r2,8(r1) then add r3,r2,r4 with out_ready = 1 -> add held for 1 cycle (in_ready = 0); one bubble cycle with out_valid = 0; add emitted next.
- wb_en = 1, wb_addr = 5, wb_data = 0x1234, rs_data = 0xDEAD, instr add r6,r5,r0 -> out_rs_val = 0x1234, out_rt_val = 0.
- beqz r7,-2 at pc 0x100 with r7 = 0 -> out_br_taken = 1 and out_br_target = 0x0FC; with r7 = 1 -> out_br_taken = 0.
- out_ready = 0 for 3 cycles with sw r4,4(r9) held -> outputs stable and in_ready = 0; in_valid instruction accepted the cycle out_ready rises.
- flush asserted with in_valid = 1 and out_valid = 1 -> next cycle out_valid = 0 and the incoming instruction is never emitted; opcode 111111 -> out_illegal = 1, mem/reg controls 0.

Source files
------------

// File: rtl/id_pkg.sv
// Shared opcodes, instruction field positions and the ID/EX record for the decode stage.
// Record data fields are sized for the widest supported configuration and cut down at the ports.
package id_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQZ  = 6'b000100;

    localparam int OPC_HI = 31;
    localparam int OPC_LO = 26;
    localparam int RS_HI  = 25;
    localparam int RS_LO  = 21;
    localparam int RT_HI  = 20;
    localparam int RT_LO  = 16;
    localparam int RD_HI  = 15;
    localparam int RD_LO  = 11;
    localparam int IMM_HI = 15;
    localparam int IMM_LO = 0;

    localparam int MAX_DATA_W = 64;
    localparam int MAX_REG_AW = 8;
    localparam int MAX_PC_W   = 64;

    typedef struct packed {
        logic [5:0]            opcode;
        logic [MAX_REG_AW-1:0] rd;
        logic [MAX_DATA_W-1:0] imm;
        logic [MAX_DATA_W-1:0] rs_val;
        logic [MAX_DATA_W-1:0] rt_val;
        logic                  mem_read;
        logic                  mem_write;
        logic                  reg_write;
        logic                  br_taken;
        logic                  illegal;
        logic [MAX_PC_W-1:0]   br_target;
    } id_ex_t;

    function automatic logic uses_rs(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) || (op == OP_BEQZ);
    endfunction

    function automatic logic uses_rt(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/id_decode.sv
// Combinational opcode decode: control bits, operand select with write-back bypass,
// sign-extended immediate and branch target.
module id_decode
    import id_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int PC_W   = 32
) (
    input  logic [31:0]       instr_i,
    input  logic [PC_W-1:0]   pc_i,
    input  logic [DATA_W-1:0] rs_data_i,
    input  logic [DATA_W-1:0] rt_data_i,
    input  logic              wb_en_i,
    input  logic [REG_AW-1:0] wb_addr_i,
    input  logic [DATA_W-1:0] wb_data_i,
    output logic [REG_AW-1:0] rs_addr_o,
    output logic [REG_AW-1:0] rt_addr_o,
    output id_ex_t            dec_o
);

    logic [5:0]        opcode;
    logic [REG_AW-1:0] rd_addr;
    logic [DATA_W-1:0] rs_val;
    logic [DATA_W-1:0] rt_val;
    logic [DATA_W-1:0] imm_ext;
    logic [PC_W-1:0]   imm_pc;
    logic [PC_W-1:0]   target;

    assign opcode    = instr_i[OPC_HI:OPC_LO];
    assign rs_addr_o = REG_AW'(instr_i[RS_HI:RS_LO]);
    assign rt_addr_o = REG_AW'(instr_i[RT_HI:RT_LO]);
    assign rd_addr   = REG_AW'(instr_i[RD_HI:RD_LO]);

    // r0 is hard-wired to zero, so it is never bypassed either.
    assign rs_val = (rs_addr_o == '0) ? '0 :
                    (wb_en_i && (wb_addr_i == rs_addr_o)) ? wb_data_i : rs_data_i;
    assign rt_val = (rt_addr_o == '0) ? '0 :
                    (wb_en_i && (wb_addr_i == rt_addr_o)) ? wb_data_i : rt_data_i;

    assign imm_ext = DATA_W'($signed(instr_i[IMM_HI:IMM_LO]));
    assign imm_pc  = PC_W'($signed(instr_i[IMM_HI:IMM_LO]));
    assign target  = pc_i + PC_W'(4) + (imm_pc << 2);

    always_comb begin
        dec_o           = '0;
        dec_o.opcode    = opcode;
        dec_o.imm       = MAX_DATA_W'(imm_ext);
        dec_o.rs_val    = MAX_DATA_W'(rs_val);
        dec_o.br_target = MAX_PC_W'(target);
        case (opcode)
            OP_RTYPE: begin
                dec_o.rd        = MAX_REG_AW'(rd_addr);
                dec_o.rt_val    = MAX_DATA_W'(rt_val);
                dec_o.reg_write = (rd_addr != '0);
            end
            OP_LW: begin
                dec_o.rd        = MAX_REG_AW'(rt_addr_o);
                dec_o.mem_read  = 1'b1;
                dec_o.reg_write = (rt_addr_o != '0);
            end
            OP_SW: begin
                dec_o.rd        = MAX_REG_AW'(rt_addr_o);
                dec_o.rt_val    = MAX_DATA_W'(rt_val);
                dec_o.mem_write = 1'b1;
            end
            OP_BEQZ: begin
                dec_o.br_taken  = (rs_val == '0);
            end
            default: begin
                dec_o.illegal   = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/id_stage_pipe.sv
// Registered decode stage: ID/EX register with valid/ready handshake, load-use stall and flush.
// Decode itself lives in id_decode.
module id_stage_pipe
    import id_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int PC_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    input  logic [PC_W-1:0]   in_pc,
    output logic [REG_AW-1:0] rs_addr,
    output logic [REG_AW-1:0] rt_addr,
    input  logic [DATA_W-1:0] rs_data,
    input  logic [DATA_W-1:0] rt_data,
    input  logic              wb_en,
    input  logic [REG_AW-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [5:0]        out_opcode,
    output logic [REG_AW-1:0] out_rd,
    output logic [DATA_W-1:0] out_imm,
    output logic [DATA_W-1:0] out_rs_val,
    output logic [DATA_W-1:0] out_rt_val,
    output logic              out_mem_read,
    output logic              out_mem_write,
    output logic              out_reg_write,
    output logic              out_br_taken,
    output logic [PC_W-1:0]   out_br_target,
    output logic              out_illegal
);

    id_ex_t            dec;
    id_ex_t            ex_q;
    id_ex_t            ex_d;
    logic              valid_q;
    logic              valid_d;
    logic              hazard;
    logic              fire_in;
    logic              fire_out;
    logic [5:0]        in_op;
    logic [REG_AW-1:0] load_rd;

    id_decode #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW),
        .PC_W   (PC_W)
    ) u_decode (
        .instr_i   (in_instr),
        .pc_i      (in_pc),
        .rs_data_i (rs_data),
        .rt_data_i (rt_data),
        .wb_en_i   (wb_en),
        .wb_addr_i (wb_addr),
        .wb_data_i (wb_data),
        .rs_addr_o (rs_addr),
        .rt_addr_o (rt_addr),
        .dec_o     (dec)
    );

    assign in_op   = in_instr[OPC_HI:OPC_LO];
    assign load_rd = ex_q.rd[REG_AW-1:0];

    // Only sources the incoming opcode actually reads can create a load-use stall.
    assign hazard = valid_q && ex_q.mem_read && (load_rd != '0) &&
                    ((uses_rs(in_op) && (load_rd == rs_addr)) ||
                     (uses_rt(in_op) && (load_rd == rt_addr)));

    assign in_ready = flush || (!hazard && (!valid_q || out_ready));
    assign fire_in  = in_valid && in_ready;
    assign fire_out = valid_q && out_ready;

    always_comb begin
        valid_d = valid_q;
        ex_d    = ex_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (fire_in) begin
            valid_d = 1'b1;
            ex_d    = dec;
        end else if (fire_out) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            ex_q    <= '0;
        end else begin
            valid_q <= valid_d;
            ex_q    <= ex_d;
        end
    end

    assign out_valid     = valid_q;
    assign out_opcode    = ex_q.opcode;
    assign out_rd        = ex_q.rd[REG_AW-1:0];
    assign out_imm       = ex_q.imm[DATA_W-1:0];
    assign out_rs_val    = ex_q.rs_val[DATA_W-1:0];
    assign out_rt_val    = ex_q.rt_val[DATA_W-1:0];
    assign out_mem_read  = ex_q.mem_read;
    assign out_mem_write = ex_q.mem_write;
    assign out_reg_write = ex_q.reg_write;
    assign out_br_taken  = ex_q.br_taken;
    assign out_br_target = ex_q.br_target[PC_W-1:0];
    assign out_illegal   = ex_q.illegal;

    // Upper record bits beyond the configured widths are intentionally dropped.
    logic unused_ex_bits;
    assign unused_ex_bits = ^ex_q;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Scoreboard bench for id_stage_pipe: directed instructions push hand-computed
// expectations; a negedge monitor pops and compares each accepted ID/EX output.
module tb_id_stage_pipe;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = '0;
    logic [31:0] in_pc = '0;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        wb_en = 1'b0;
    logic [4:0]  wb_addr = '0;
    logic [31:0] wb_data = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [5:0]  out_opcode;
    logic [4:0]  out_rd;
    logic [31:0] out_imm;
    logic [31:0] out_rs_val;
    logic [31:0] out_rt_val;
    logic        out_mem_read;
    logic        out_mem_write;
    logic        out_reg_write;
    logic        out_br_taken;
    logic [31:0] out_br_target;
    logic        out_illegal;

    always #5 clk = ~clk;

    id_stage_pipe #(.DATA_W(32), .REG_AW(5), .PC_W(32)) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_instr      (in_instr),
        .in_pc         (in_pc),
        .rs_addr       (rs_addr),
        .rt_addr       (rt_addr),
        .rs_data       (rs_data),
        .rt_data       (rt_data),
        .wb_en         (wb_en),
        .wb_addr       (wb_addr),
        .wb_data       (wb_data),
        .flush         (flush),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_opcode    (out_opcode),
        .out_rd        (out_rd),
        .out_imm       (out_imm),
        .out_rs_val    (out_rs_val),
        .out_rt_val    (out_rt_val),
        .out_mem_read  (out_mem_read),
        .out_mem_write (out_mem_write),
        .out_reg_write (out_reg_write),
        .out_br_taken  (out_br_taken),
        .out_br_target (out_br_target),
        .out_illegal   (out_illegal)
    );

    typedef struct packed {
        logic [5:0]  op;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [31:0] rsv;
        logic [31:0] rtv;
        logic        mr;
        logic        mw;
        logic        rw;
        logic        bt;
        logic        ill;
        logic [31:0] tgt;
    } exp_t;

    exp_t sb[$];
    exp_t act;
    int   checks = 0;
    int   errors = 0;
    logic [31:0] rf [32];

    assign rs_data = rf[rs_addr];
    assign rt_data = rf[rt_addr];

    always_comb begin
        act = {out_opcode, out_rd, out_imm, out_rs_val, out_rt_val, out_mem_read,
               out_mem_write, out_reg_write, out_br_taken, out_illegal, out_br_target};
    end

    function automatic exp_t mk(input logic [5:0] op, input logic [4:0] rd, input logic [31:0] imm,
                                input logic [31:0] rsv, input logic [31:0] rtv, input logic mr,
                                input logic mw, input logic rw, input logic bt, input logic ill,
                                input logic [31:0] tgt);
        return '{op, rd, imm, rsv, rtv, mr, mw, rw, bt, ill, tgt};
    endfunction

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        return {6'b000000, rs, rt, rd, 5'b00000, 6'h20};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    task automatic chk_out(input string name, input exp_t want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, act, want);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!reset && out_valid && out_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_out got=%h want=none", act);
            end else begin
                e = sb.pop_front();
                if (act !== e) begin
                    errors++;
                    $display("FAIL out_txn got=%h want=%h", act, e);
                end else begin
                    $display("txn op=%h rd=%0d rs=%h rt=%h tgt=%h ok", out_opcode, out_rd,
                             out_rs_val, out_rt_val, out_br_target);
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [31:0] instr, input logic [31:0] pc, input exp_t e, input bit expect_it);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_instr = instr;
        in_pc    = pc;
        @(negedge clk);
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout got=in_ready0 want=in_ready1");
        end else if (expect_it) begin
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 32'h100 + i;
        rf[7] = 32'h0;
        rf[5] = 32'hDEAD;

        // Power-on reset
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_ctrl", 64'({out_mem_read, out_mem_write, out_reg_write, out_br_taken, out_illegal}), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        idle(1);

        // Reset while an instruction is held
        out_ready = 1'b0;
        send(rtype(5'd1, 5'd2, 5'd3), 32'h0, '0, 1'b0);
        chk("pre_reset_valid", 64'(out_valid), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_valid", 64'(out_valid), 64'd0);
        chk("async_rst_ctrl", 64'({out_mem_read, out_mem_write, out_reg_write, out_br_taken, out_illegal}), 64'd0);
        chk("async_rst_data", 64'(out_rs_val), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        out_ready = 1'b1;
        idle(1);

        // lw r2,8(r1) then dependent add r3,r2,r4
        send(itype(6'h23, 5'd1, 5'd2, 16'd8), 32'h10,
             mk(6'h23, 5'd2, 32'h8, 32'h101, 32'h0, 1, 0, 1, 0, 0, 32'h34), 1'b1);
        chk("first_latency", 64'(out_valid), 64'd1);
        in_valid = 1'b1;
        in_instr = rtype(5'd2, 5'd4, 5'd3);
        in_pc    = 32'h14;
        @(negedge clk);
        chk("hazard_stall", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("bubble", 64'(out_valid), 64'd0);
        chk("dep_accept", 64'(in_ready), 64'd1);
        if (in_ready) sb.push_back(mk(6'h00, 5'd3, 32'h1820, 32'h102, 32'h104, 0, 0, 1, 0, 0, 32'h6098));
        @(posedge clk);
        #1;
        in_valid = 1'b0;

        // Write-back bypass on each operand, r0 forced to zero
        wb_en = 1'b1;
        wb_addr = 5'd5;
        wb_data = 32'h1234;
        send(rtype(5'd5, 5'd0, 5'd6), 32'h20,
             mk(6'h00, 5'd6, 32'h3020, 32'h1234, 32'h0, 0, 0, 1, 0, 0, 32'hC0A4), 1'b1);
        send(rtype(5'd0, 5'd5, 5'd6), 32'h24,
             mk(6'h00, 5'd6, 32'h3020, 32'h0, 32'h1234, 0, 0, 1, 0, 0, 32'hC0A8), 1'b1);
        wb_en = 1'b0;

        // beqz r7,-2: taken, not taken, taken via bypass
        send(itype(6'h04, 5'd7, 5'd0, 16'hFFFE), 32'h100,
             mk(6'h04, 5'd0, 32'hFFFFFFFE, 32'h0, 32'h0, 0, 0, 0, 1, 0, 32'hFC), 1'b1);
        rf[7] = 32'h1;
        send(itype(6'h04, 5'd7, 5'd0, 16'hFFFE), 32'h104,
             mk(6'h04, 5'd0, 32'hFFFFFFFE, 32'h1, 32'h0, 0, 0, 0, 0, 0, 32'h100), 1'b1);
        wb_en = 1'b1;
        wb_addr = 5'd7;
        wb_data = 32'h0;
        send(itype(6'h04, 5'd7, 5'd0, 16'hFFFE), 32'h108,
             mk(6'h04, 5'd0, 32'hFFFFFFFE, 32'h0, 32'h0, 0, 0, 0, 1, 0, 32'h104), 1'b1);
        wb_en = 1'b0;
        idle(1);

        // sw r4,4(r9) held for 3 cycles
        out_ready = 1'b0;
        send(itype(6'h2B, 5'd9, 5'd4, 16'd4), 32'h40,
             mk(6'h2B, 5'd4, 32'h4, 32'h109, 32'h104, 0, 1, 0, 0, 0, 32'h54), 1'b1);
        in_valid = 1'b1;
        in_instr = rtype(5'd2, 5'd3, 5'd1);
        in_pc    = 32'h44;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("hold_ready", 64'(in_ready), 64'd0);
            chk_out("hold_stable", mk(6'h2B, 5'd4, 32'h4, 32'h109, 32'h104, 0, 1, 0, 0, 0, 32'h54));
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("release_ready", 64'(in_ready), 64'd1);
        if (in_ready) sb.push_back(mk(6'h00, 5'd1, 32'h820, 32'h102, 32'h103, 0, 0, 1, 0, 0, 32'h20C8));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        idle(1);

        // Flush a held lw while a dependent instruction is offered
        out_ready = 1'b0;
        send(itype(6'h23, 5'd0, 5'd8, 16'd0), 32'h50, '0, 1'b0);
        in_valid = 1'b1;
        in_instr = rtype(5'd8, 5'd0, 5'd1);
        in_pc    = 32'h54;
        flush    = 1'b1;
        @(negedge clk);
        chk("flush_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("flush_clear", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;

        // Unknown opcode
        send(32'hFC000000, 32'h60,
             mk(6'h3F, 5'd0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 0, 1, 32'h64), 1'b1);
        idle(3);
        chk("sb_drain", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
